// File: rtl/dnn_seq_pkg.sv
// Shared types and default configuration for the DNN weight sequencer.
// The LNN array length is fixed by SEQ_NUM_LAYERS; the counter width is sized for the default shape.
package dnn_seq_pkg;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ARM, S_RUN} seq_state_e;

  localparam int SEQ_NUM_LAYERS = 2;
  localparam int SEQ_MAX_NERVES = 5;
  localparam int SEQ_W_BITS     = 4;
  localparam int SEQ_IMAGE_SIZE = 4;

  typedef int lnn_t [SEQ_NUM_LAYERS];
  localparam lnn_t SEQ_LNN = '{2, 5};

  // Words loaded into layer i equal the fan-in of that layer.
  function automatic int layer_words(input int i, input int image_size, input lnn_t lnn);
    return (i == 0) ? image_size : lnn[SEQ_NUM_LAYERS - i];
  endfunction

  function automatic int max_layer_words();
    int m;
    m = SEQ_IMAGE_SIZE;
    for (int i = 1; i < SEQ_NUM_LAYERS; i++)
      if (SEQ_LNN[SEQ_NUM_LAYERS - i] > m) m = SEQ_LNN[SEQ_NUM_LAYERS - i];
    return m;
  endfunction

  localparam int SEQ_CNT_W = $clog2(max_layer_words() + 1);

endpackage

// File: rtl/dnn_weight_sequencer.sv
// Loads per-layer weights into the FC back end, arms it, then runs RunCount inference passes.
// Optional DNN_SEQ_ABORT_EN adds in_abort, which drops any active sequence back to IDLE.
module dnn_weight_sequencer
  import dnn_seq_pkg::*;
#(
  parameter int   NumLayers    = SEQ_NUM_LAYERS,
  parameter int   MaxNumNerves = SEQ_MAX_NERVES,
  parameter int   M_W_BitSize  = SEQ_W_BITS,
  parameter int   ImageSize    = SEQ_IMAGE_SIZE,
  parameter lnn_t LNN          = SEQ_LNN,
  parameter int   RunCount     = 1
) (
  input  logic                                     clk,
  input  logic                                     res,
  input  logic                                     in_start,
  input  logic                                     in_w_valid,
  input  logic [MaxNumNerves-1:0][M_W_BitSize-1:0] in_w_data,
`ifdef DNN_SEQ_ABORT_EN
  input  logic                                     in_abort,
`endif
  output logic                                     out_w_ready,
  output logic [MaxNumNerves-1:0][M_W_BitSize-1:0] out_weights,
  output logic [NumLayers-1:0]                     out_layer_en,
  output logic [NumLayers-2:0]                     out_weight_en_posedge,
  output logic                                     out_fl_res,
  input  logic                                     in_dnn_ready,
  input  logic                                     in_dnn_done,
  output logic                                     out_busy,
  output logic                                     out_run_done
);

  localparam int LW = (NumLayers > 1) ? $clog2(NumLayers) : 1;
  localparam int RW = (RunCount > 1) ? $clog2(RunCount) : 1;

  seq_state_e                               r_state;
  logic [LW-1:0]                            r_layer;
  logic [SEQ_CNT_W-1:0]                     r_cnt;
  logic [RW-1:0]                            r_run;
  logic                                     r_done_q;
  logic                                     r_w_ready;
  logic [MaxNumNerves-1:0][M_W_BitSize-1:0] r_weights;
  logic [NumLayers-1:0]                     r_layer_en;
  logic [NumLayers-2:0]                     r_wen;
  logic [NumLayers-2:0]                     r_wen_pend;
  logic                                     r_fl_res;
  logic                                     r_run_done;

  logic                                     w_accept;
  logic                                     w_abort;
  logic                                     w_done_edge;
  logic [SEQ_CNT_W-1:0]                     w_last_cnt;
  int                                       w_keep_from;
  logic [MaxNumNerves-1:0][M_W_BitSize-1:0] w_masked;

  assign w_accept    = (r_state == S_LOAD) && r_w_ready && in_w_valid;
  assign w_done_edge = in_dnn_done && !r_done_q;

`ifdef DNN_SEQ_ABORT_EN
  assign w_abort = in_abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // Per-layer word count and the lowest lane that layer actually uses.
  always_comb begin
    w_last_cnt  = '0;
    w_keep_from = 0;
    for (int l = 0; l < NumLayers; l++)
      if (r_layer == LW'(l)) begin
        w_last_cnt  = SEQ_CNT_W'(layer_words(l, ImageSize, LNN) - 1);
        w_keep_from = MaxNumNerves - LNN[NumLayers-1-l];
      end
    for (int n = 0; n < MaxNumNerves; n++)
      w_masked[n] = (n >= w_keep_from) ? in_w_data[n] : '0;
  end

  always_ff @(posedge clk) begin
    if (res || w_abort) begin
      r_state    <= S_IDLE;
      r_layer    <= '0;
      r_cnt      <= '0;
      r_run      <= '0;
      r_done_q   <= 1'b0;
      r_w_ready  <= 1'b0;
      r_weights  <= '0;
      r_layer_en <= '0;
      r_wen      <= '0;
      r_wen_pend <= '0;
      r_fl_res   <= 1'b1;
      r_run_done <= 1'b0;
    end else begin
      r_layer_en <= '0;
      r_run_done <= 1'b0;
      r_wen_pend <= '0;
      // Release lands one cycle after the layer's final capture strobe.
      r_wen      <= r_wen | r_wen_pend;
      r_done_q   <= (r_state == S_IDLE) ? 1'b0 : in_dnn_done;
      if (w_accept) begin
        r_weights  <= w_masked;
        r_layer_en <= NumLayers'(1) << r_layer;
      end
      case (r_state)
        S_IDLE: if (in_start) begin
          r_state   <= S_LOAD;
          r_layer   <= '0;
          r_cnt     <= '0;
          r_w_ready <= 1'b1;
        end
        S_LOAD: if (w_accept) begin
          if (r_cnt == w_last_cnt) begin
            r_cnt <= '0;
            for (int l = 1; l < NumLayers; l++)
              if (r_layer == LW'(l)) r_wen_pend[l-1] <= 1'b1;
            if (r_layer == LW'(NumLayers - 1)) begin
              r_state   <= S_ARM;
              r_w_ready <= 1'b0;
            end else begin
              r_layer <= r_layer + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ARM: if (in_dnn_ready) begin
          r_state  <= S_RUN;
          r_run    <= '0;
          r_fl_res <= 1'b0;
        end
        S_RUN: if (w_done_edge) begin
          if (r_run == RW'(RunCount - 1)) begin
            r_run_done <= 1'b1;
            r_state    <= S_IDLE;
            r_fl_res   <= 1'b1;
            r_wen      <= '0;
          end else begin
            r_run <= r_run + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_w_ready           = r_w_ready;
  assign out_weights           = r_weights;
  assign out_layer_en          = r_layer_en;
  assign out_weight_en_posedge = r_wen;
  assign out_fl_res            = r_fl_res;
  assign out_busy              = (r_state != S_IDLE);
  assign out_run_done          = r_run_done;

endmodule

// File: tb/tb_dnn_weight_sequencer.sv
// Directed bench for dnn_weight_sequencer (RunCount=3, other parameters default).
// The abort scenario is compiled in when DNN_SEQ_ABORT_EN is defined.
module tb_dnn_weight_sequencer;

  logic             clk = 1'b0;
  logic             res;
  logic             in_start;
  logic             in_w_valid;
  logic [4:0][3:0]  in_w_data;
  logic             in_dnn_ready;
  logic             in_dnn_done;
  logic             out_w_ready;
  logic [4:0][3:0]  out_weights;
  logic [1:0]       out_layer_en;
  logic [0:0]       out_weight_en_posedge;
  logic             out_fl_res;
  logic             out_busy;
  logic             out_run_done;
`ifdef DNN_SEQ_ABORT_EN
  logic             in_abort;
`endif

  int checks = 0;
  int errors = 0;

  logic [19:0] data_tab [9] = '{20'h12345, 20'h6789A, 20'hBCDEF, 20'h0F1E2, 20'hA5A5A,
                                20'h3C3C3, 20'hFFFFF, 20'h80001, 20'h7E5D4};
  logic [19:0] exp_tab  [9] = '{20'h12345, 20'h6789A, 20'hBCDEF, 20'h0F1E2, 20'hA5000,
                                20'h3C000, 20'hFF000, 20'h80000, 20'h7E000};
  logic [1:0]  en_tab   [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};

  dnn_weight_sequencer #(.RunCount(3)) dut (
    .clk                   (clk),
    .res                   (res),
    .in_start              (in_start),
    .in_w_valid            (in_w_valid),
    .in_w_data             (in_w_data),
`ifdef DNN_SEQ_ABORT_EN
    .in_abort              (in_abort),
`endif
    .out_w_ready           (out_w_ready),
    .out_weights           (out_weights),
    .out_layer_en          (out_layer_en),
    .out_weight_en_posedge (out_weight_en_posedge),
    .out_fl_res            (out_fl_res),
    .in_dnn_ready          (in_dnn_ready),
    .in_dnn_done           (in_dnn_done),
    .out_busy              (out_busy),
    .out_run_done          (out_run_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b1; in_start = 1'b0; in_w_valid = 1'b0; in_w_data = '0;
    in_dnn_ready = 1'b0; in_dnn_done = 1'b0;
`ifdef DNN_SEQ_ABORT_EN
    in_abort = 1'b0;
`endif
    tick(); tick();
    res = 1'b0;
    checks++; if (out_w_ready !== 1'b0) begin errors++; $display("FAIL rst_w_ready: got %b exp 0", out_w_ready); end
    checks++; if (out_weights !== 20'h0) begin errors++; $display("FAIL rst_weights: got %h exp 00000", out_weights); end
    checks++; if (out_layer_en !== 2'b00) begin errors++; $display("FAIL rst_layer_en: got %b exp 00", out_layer_en); end
    checks++; if (out_weight_en_posedge !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b exp 0", out_weight_en_posedge); end
    checks++; if (out_fl_res !== 1'b1) begin errors++; $display("FAIL rst_fl_res: got %b exp 1", out_fl_res); end
    checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", out_busy); end
    checks++; if (out_run_done !== 1'b0) begin errors++; $display("FAIL rst_run_done: got %b exp 0", out_run_done); end
  endtask

  task automatic test_load_continuous();
    in_start = 1'b1; tick(); in_start = 1'b0;
    checks++; if (out_busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %b exp 1", out_busy); end
    checks++; if (out_w_ready !== 1'b1) begin errors++; $display("FAIL load_w_ready: got %b exp 1", out_w_ready); end
    in_w_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      in_w_data = data_tab[k];
      tick();
      checks++; if (out_layer_en !== en_tab[k]) begin errors++; $display("FAIL load_en[%0d]: got %b exp %b", k, out_layer_en, en_tab[k]); end
      checks++; if (out_weights !== exp_tab[k]) begin errors++; $display("FAIL load_w[%0d]: got %h exp %h", k, out_weights, exp_tab[k]); end
      checks++; if (out_weight_en_posedge !== 1'b0) begin errors++; $display("FAIL load_wen[%0d]: got %b exp 0", k, out_weight_en_posedge); end
    end
    in_w_valid = 1'b0;
    checks++; if (out_w_ready !== 1'b0) begin errors++; $display("FAIL arm_w_ready: got %b exp 0", out_w_ready); end
    tick();
    checks++; if (out_weight_en_posedge !== 1'b1) begin errors++; $display("FAIL arm_wen_rise: got %b exp 1", out_weight_en_posedge); end
    checks++; if (out_layer_en !== 2'b00) begin errors++; $display("FAIL arm_en_idle: got %b exp 00", out_layer_en); end
  endtask

  task automatic test_arm_wait();
    for (int i = 0; i < 10; i++) begin
      in_start = (i == 3);
      tick();
      checks++; if (out_fl_res !== 1'b1) begin errors++; $display("FAIL arm_fl_res[%0d]: got %b exp 1", i, out_fl_res); end
      checks++; if (out_w_ready !== 1'b0 || out_busy !== 1'b1) begin errors++; $display("FAIL arm_hold[%0d]: got ready=%b busy=%b exp 0 1", i, out_w_ready, out_busy); end
    end
    in_start = 1'b0;
    in_dnn_ready = 1'b1; tick(); in_dnn_ready = 1'b0;
    checks++; if (out_fl_res !== 1'b0) begin errors++; $display("FAIL run_fl_res: got %b exp 0", out_fl_res); end
    checks++; if (out_weight_en_posedge !== 1'b1) begin errors++; $display("FAIL run_wen: got %b exp 1", out_weight_en_posedge); end
  endtask

  task automatic test_run_count();
    in_dnn_done = 1'b1; tick(); in_dnn_done = 1'b0; tick();
    checks++; if (out_run_done !== 1'b0 || out_busy !== 1'b1) begin errors++; $display("FAIL run_p1: got done=%b busy=%b exp 0 1", out_run_done, out_busy); end
    in_dnn_done = 1'b1; tick(); tick(); tick(); in_dnn_done = 1'b0; tick();
    checks++; if (out_run_done !== 1'b0 || out_busy !== 1'b1) begin errors++; $display("FAIL run_p2_held: got done=%b busy=%b exp 0 1", out_run_done, out_busy); end
    in_dnn_done = 1'b1; tick();
    checks++; if (out_run_done !== 1'b1) begin errors++; $display("FAIL run_done_pulse: got %b exp 1", out_run_done); end
    checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL run_idle_busy: got %b exp 0", out_busy); end
    checks++; if (out_fl_res !== 1'b1 || out_weight_en_posedge !== 1'b0) begin errors++; $display("FAIL run_idle_outs: got fl_res=%b wen=%b exp 1 0", out_fl_res, out_weight_en_posedge); end
    in_dnn_done = 1'b0; tick();
    checks++; if (out_run_done !== 1'b0) begin errors++; $display("FAIL run_done_once: got %b exp 0", out_run_done); end
  endtask

  task automatic test_valid_toggle();
    in_start = 1'b1; tick(); in_start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in_w_valid = 1'b1; in_w_data = data_tab[k];
      tick();
      checks++; if (out_layer_en !== en_tab[k] || out_weights !== exp_tab[k]) begin errors++; $display("FAIL tog_cap[%0d]: got en=%b w=%h exp en=%b w=%h", k, out_layer_en, out_weights, en_tab[k], exp_tab[k]); end
      in_w_valid = 1'b0; in_w_data = 20'h55555;
      tick();
      checks++; if (out_layer_en !== 2'b00 || out_weights !== exp_tab[k]) begin errors++; $display("FAIL tog_gap[%0d]: got en=%b w=%h exp en=00 w=%h", k, out_layer_en, out_weights, exp_tab[k]); end
    end
    checks++; if (out_weight_en_posedge !== 1'b1 || out_w_ready !== 1'b0) begin errors++; $display("FAIL tog_arm: got wen=%b ready=%b exp 1 0", out_weight_en_posedge, out_w_ready); end
    res = 1'b1; tick(); res = 1'b0;
  endtask

  task automatic test_reset_midload();
    in_start = 1'b1; tick(); in_start = 1'b0;
    in_w_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_w_data = data_tab[k];
      tick();
    end
    checks++; if (out_layer_en !== 2'b10) begin errors++; $display("FAIL mid_pre: got %b exp 10", out_layer_en); end
    res = 1'b1; in_w_valid = 1'b0; tick(); res = 1'b0;
    checks++; if (out_w_ready !== 1'b0 || out_busy !== 1'b0 || out_run_done !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl: got ready=%b busy=%b done=%b exp 0 0 0", out_w_ready, out_busy, out_run_done); end
    checks++; if (out_weights !== 20'h0 || out_layer_en !== 2'b00) begin errors++; $display("FAIL mid_rst_data: got w=%h en=%b exp 00000 00", out_weights, out_layer_en); end
    checks++; if (out_fl_res !== 1'b1 || out_weight_en_posedge !== 1'b0) begin errors++; $display("FAIL mid_rst_res: got fl_res=%b wen=%b exp 1 0", out_fl_res, out_weight_en_posedge); end
    in_start = 1'b1; tick(); in_start = 1'b0;
    in_w_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_w_data = data_tab[k];
      tick();
      checks++; if (out_layer_en !== en_tab[k] || out_weights !== exp_tab[k]) begin errors++; $display("FAIL mid_restart[%0d]: got en=%b w=%h exp en=%b w=%h", k, out_layer_en, out_weights, en_tab[k], exp_tab[k]); end
    end
    in_w_valid = 1'b0;
    res = 1'b1; tick(); res = 1'b0;
  endtask

`ifdef DNN_SEQ_ABORT_EN
  task automatic test_abort();
    in_start = 1'b1; tick(); in_start = 1'b0;
    in_w_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      in_w_data = data_tab[k];
      tick();
    end
    in_w_valid = 1'b0;
    in_dnn_ready = 1'b1; tick(); in_dnn_ready = 1'b0;
    checks++; if (out_fl_res !== 1'b0) begin errors++; $display("FAIL abort_run: got fl_res=%b exp 0", out_fl_res); end
    for (int p = 0; p < 2; p++) begin
      in_dnn_done = 1'b1; tick(); in_dnn_done = 1'b0; tick();
    end
    in_dnn_done = 1'b1; in_abort = 1'b1; tick(); in_abort = 1'b0; in_dnn_done = 1'b0;
    checks++; if (out_run_done !== 1'b0 || out_busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got done=%b busy=%b exp 0 0", out_run_done, out_busy); end
    checks++; if (out_fl_res !== 1'b1 || out_weights !== 20'h0 || out_weight_en_posedge !== 1'b0) begin errors++; $display("FAIL abort_outs: got fl_res=%b w=%h wen=%b exp 1 00000 0", out_fl_res, out_weights, out_weight_en_posedge); end
    tick();
    checks++; if (out_run_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b exp 0", out_run_done); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_continuous();
    test_arm_wait();
    test_run_count();
    test_valid_toggle();
    test_reset_midload();
`ifdef DNN_SEQ_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dnn_weight_sequencer.md
# dnn_weight_sequencer

Controller that sequences the fully-connected back end of the network (flattening layer plus chained systolic-array layers). It streams per-layer weights from an upstream weight source into each layer in order and holds the flattening layer and not-yet-loaded layers in reset. Once all layers are armed it runs a fixed number of inference passes, counting completions, and then returns to idle. It sits between the weight memory/DMA and the `dnn_top` datapath.

## Interface
- `NumLayers`, 2, number of systolic-array layers
- `MaxNumNerves`, 5, lanes on the weight bus
- `M_W_BitSize`, 4, bits per weight lane
- `ImageSize`, 4, inputs to layer 0
- `LNN`, '{2, 5}, nerves per layer; layer i is entry `LNN[NumLayers-1-i]`
- `RunCount`, 1, `in_dnn_done` pulses per run; must be ≥1
- `clk` in 1: single clock; all logic on posedge
- `res` in 1: reset, synchronous and active-high
- `in_start` in 1: pulse that begins a load-and-run
- `in_w_valid` in 1: weight word valid
- `in_w_data` in [MaxNumNerves-1:0][M_W_BitSize-1:0]: weight word
- `out_w_ready` out 1: accept weight word
- `out_weights` out [MaxNumNerves-1:0][M_W_BitSize-1:0]: registered weights to the datapath
- `out_layer_en` out NumLayers: one-hot, layer capturing `out_weights` this cycle
- `out_weight_en_posedge` out NumLayers-1: bit j releases layer j+1 from reset
- `out_fl_res` out 1: flattening-layer reset, active-high
- `in_dnn_ready` in 1: datapath `out_ready`
- `in_dnn_done` in 1: datapath `out_done`
- `out_busy` out 1: state ≠ IDLE
- `out_run_done` out 1: one-cycle pulse at end of run

## Operation
- States: IDLE, LOAD, ARM, RUN.
- IDLE:
  - `out_w_ready`=0, `out_fl_res`=1, all enables 0.
  - `in_start` → LOAD with layer index L=0 and word counter C=0.
- LOAD:
  - `out_w_ready`=1.
  - Each accepted word (`in_w_valid && out_w_ready`) increments C.
  - Words required for layer L: W(0)=`ImageSize`; W(L)=`LNN[NumLayers-L]` for L>0.
  - Lanes below `MaxNumNerves-LNN[NumLayers-1-L]` are forced to 0 in `out_weights`.
  - On the accept with C=W(L)-1:
    - C←0.
    - If L>0, set `out_weight_en_posedge[L-1]`.
    - If L=NumLayers-1, go to ARM; otherwise L←L+1.
  - `in_w_valid` low stalls the counter; there is no timeout.
- ARM:
  - `out_w_ready`=0.
  - Waits for `in_dnn_ready`=1, then → RUN with run counter R=0.
  - `out_fl_res` drops to 0 on entry to RUN.
- RUN:
  - Each `in_dnn_done` rising edge increments R.
  - At R=RunCount-1 with an edge: pulse `out_run_done`, go to IDLE.
  - `out_weight_en_posedge` and `out_fl_res` are restored to their reset values on return to IDLE.
- `in_start` outside IDLE is ignored.
- `res` in any state:
  - Returns to IDLE next edge.
  - Clears counters and all outputs to their reset values; a partial load is discarded.
- Reset values: `out_w_ready`=0, `out_weights`=0, `out_layer_en`=0, `out_weight_en_posedge`=0, `out_fl_res`=1, `out_busy`=0, `out_run_done`=0.

## Timing
- `out_weights` and `out_layer_en` are registered one cycle after the accepting edge and are always aligned with each other.
- `out_layer_en` is high exactly W(L) cycles per layer, not necessarily contiguous.
- The `out_weight_en_posedge` bit rises in the cycle after the last `out_layer_en` of its layer.
- ARM→RUN takes 1 cycle after `in_dnn_ready` is sampled high.
- `out_run_done` is high for one cycle; IDLE is entered on the same edge.
- The `in_dnn_done` edge is detected against a 1-cycle delayed copy, which is cleared in IDLE.
- Minimum load length: sum of W(L) cycles plus 1 pipeline cycle.

## Configuration
- `DNN_SEQ_ABORT_EN` defined:
  - Adds input port `in_abort`.
  - From LOAD, ARM or RUN, `in_abort` forces IDLE next edge with reset-value outputs and no `out_run_done`.
  - `in_abort` has priority over all transitions except `res`.
- `DNN_SEQ_ABORT_EN` undefined: the port is absent; only `res` aborts.

## Structure
- Shared package `dnn_seq_pkg`:
  - State enum.
  - Constant function `layer_words(i)` returning W(i).
  - Counter width constant `$clog2(max W + 1)`.
- Single module; no sub-module. Counters and the FSM are inline.

## Test plan
- Defaults, continuous `in_w_valid`: 4 words to layer 0 (`out_layer_en`=01), then 5 words to layer 1 (`out_layer_en`=10, lanes [2:0] zeroed); `out_weight_en_posedge`[0] rises 1 cycle after the 9th `out_layer_en`.
- `in_w_valid` toggled 1/0: the same 9 captures occur over 18 cycles; C holds while valid is low.
- ARM with `in_dnn_ready` held 0 for 10 cycles, then 1: RUN entered 1 cycle later; `out_fl_res` drops then.
- RunCount=3, three `in_dnn_done` pulses: `out_run_done` pulses once after the 3rd; `out_busy`=0 next cycle.
- `res` asserted after 2 words of layer 1: next cycle all outputs at reset values; a new `in_start` restarts from layer 0.
- With `DNN_SEQ_ABORT_EN`, `in_abort` in RUN simultaneous with the final `in_dnn_done`: IDLE, no `out_run_done`.
